bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_sub3.sv | 16 +
 rtl/bcd_to_bin.sv | 128 ++++++++++++
 tb/tb_bcd_to_bin.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD to binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ = 4'd3;

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit correction after a right shift: d >= 8 gives d-3
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  always_comb begin
    q = d;
    if (d >= 4'd8) begin
      q = d - BCD_ADJ;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - iterative BCD to binary converter (reverse double dabble); BCD2BIN_ERR_CHECK_EN adds invalid-digit detection
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  bcd_digit_t           bcd_in [DIGITS],
  output logic                 ready,
  output logic                 done_tick,
  output logic [BIN_WIDTH-1:0] bin_out,
  output logic                 err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  bcd_state_t           state;
  logic [BCD_W-1:0]     bcd_shift;
  logic [BCD_W-1:0]     bcd_shifted;
  logic [BCD_W-1:0]     bcd_next;
  logic [BCD_W-1:0]     bcd_load;
  logic [BIN_WIDTH-1:0] bin_shift;
  logic [BIN_WIDTH-1:0] bin_next;
  logic [CNT_W-1:0]     iter_cnt;

  // One iteration: the whole {bcd, bin} pair moves right, then each BCD digit is corrected.
  always_comb begin
    {bcd_shifted, bin_next} = {bcd_shift, bin_shift} >> 1;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d (bcd_shifted[4*g +: 4]),
      .q (bcd_next[4*g +: 4])
    );
    assign bcd_load[4*g +: 4] = bcd_in[g];
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic any_invalid;

  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i] > 4'd9) begin
        any_invalid = 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      bin_out   <= '0;
      bcd_shift <= '0;
      bin_shift <= '0;
      iter_cnt  <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          ready     <= 1'b1;
          done_tick <= 1'b0;
          if (start) begin
            ready <= 1'b0;
`ifdef BCD2BIN_ERR_CHECK_EN
            if (any_invalid) begin
              state     <= ST_DONE;
              done_tick <= 1'b1;
              bin_out   <= '0;
              err       <= 1'b1;
            end else begin
              state     <= ST_OP;
              bcd_shift <= bcd_load;
              bin_shift <= '0;
              iter_cnt  <= CNT_W'(BIN_WIDTH);
            end
`else
            state     <= ST_OP;
            bcd_shift <= bcd_load;
            bin_shift <= '0;
            iter_cnt  <= CNT_W'(BIN_WIDTH);
`endif
          end
        end

        ST_OP: begin
          bcd_shift <= bcd_next;
          bin_shift <= bin_next;
          iter_cnt  <= iter_cnt - CNT_W'(1);
          if (iter_cnt == CNT_W'(1)) begin
            // Final iteration: publish the completed value straight from the next-state logic.
            state     <= ST_DONE;
            done_tick <= 1'b1;
            bin_out   <= bin_next;
`ifdef BCD2BIN_ERR_CHECK_EN
            err       <= 1'b0;
`endif
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          done_tick <= 1'b0;
          ready     <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          done_tick <= 1'b0;
          ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin with a randomized arithmetic reference
module tb_bcd_to_bin;

  localparam int DIGITS    = 4;
  localparam int BIN_WIDTH = 14;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [3:0]           bcd_in [DIGITS];
  logic                 ready;
  logic                 done_tick;
  logic [BIN_WIDTH-1:0] bin_out;
  logic                 err;

  int checks;
  int failures;
  logic [BIN_WIDTH-1:0] exp_bin_out;

  bcd_to_bin #(
    .DIGITS    (DIGITS),
    .BIN_WIDTH (BIN_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd_in    (bcd_in),
    .ready     (ready),
    .done_tick (done_tick),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input logic [15:0] word);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s = s + int'(word[4*i +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  task automatic set_bcd(input logic [15:0] word);
    for (int i = 0; i < DIGITS; i++) bcd_in[i] = word[4*i +: 4];
  endtask

  // Starts one conversion from idle; n=0 is the sample right after the accepting edge.
  task automatic run_conv(input logic [15:0] word, input int poke_cycle, input logic [15:0] poke_word,
                          output int lat, output logic [BIN_WIDTH-1:0] res, output logic e);
    logic ready_bad;
    logic hold_bad;
    logic [BIN_WIDTH-1:0] bad_val;
    ready_bad = 1'b0;
    hold_bad  = 1'b0;
    bad_val   = '0;
    lat = -1;
    res = '0;
    e   = 1'b0;
    set_bcd(word);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= BIN_WIDTH + 6; n++) begin
      if (n > 0) @(negedge clk);
      if (poke_cycle > 0 && n == poke_cycle) begin
        start = 1'b1;
        set_bcd(poke_word);
      end else if (poke_cycle > 0 && n == poke_cycle + 1) begin
        start = 1'b0;
      end
      if (done_tick === 1'b1) begin
        lat = n;
        res = bin_out;
        e   = err;
        break;
      end
      if (ready !== 1'b0) ready_bad = 1'b1;
      if (bin_out !== exp_bin_out && !hold_bad) begin
        hold_bad = 1'b1;
        bad_val  = bin_out;
      end
    end
    start = 1'b0;
    checks++;
    if (ready_bad) begin
      failures++;
      $display("FAIL ready_low_in_op word=%h: ready went high before done, required 0", word);
    end
    checks++;
    if (hold_bad) begin
      failures++;
      $display("FAIL bin_out_hold word=%h: got %0d during op, required %0d", word, bad_val, exp_bin_out);
    end
    @(negedge clk);
    checks++;
    if (done_tick !== 1'b0) begin
      failures++;
      $display("FAIL done_width word=%h: done_tick=%b one cycle later, required 0", word, done_tick);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_done word=%h: ready=%b, required 1", word, ready);
    end
  endtask

  task automatic check_conv(input string name, input logic [15:0] word, input int exp_lat,
                            input int exp_val, input logic exp_err, input int poke_cycle,
                            input logic [15:0] poke_word);
    int lat;
    logic [BIN_WIDTH-1:0] res;
    logic e;
    run_conv(word, poke_cycle, poke_word, lat, res, e);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency word=%h: got %0d, required %0d", name, word, lat, exp_lat);
    end
    checks++;
    if (res !== BIN_WIDTH'(exp_val)) begin
      failures++;
      $display("FAIL %s_value word=%h: got %0d, required %0d", name, word, res, exp_val);
    end
    checks++;
    if (e !== exp_err) begin
      failures++;
      $display("FAIL %s_err word=%h: got %b, required %b", name, word, e, exp_err);
    end
    exp_bin_out = BIN_WIDTH'(exp_val);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    set_bcd(16'h0000);
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, done_tick, bin_out, err} !== {1'b1, 1'b0, {BIN_WIDTH{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b bin=%0d err=%b, required 1 0 0 0", ready, done_tick, bin_out, err);
    end
    reset = 1'b0;
    exp_bin_out = '0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    check_conv("zero", 16'h0000, BIN_WIDTH, 0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_extremes();
    check_conv("nines", 16'h9999, BIN_WIDTH, 9999, 1'b0, 0, 16'h0);
    check_conv("d1234", 16'h1234, BIN_WIDTH, 1234, 1'b0, 0, 16'h0);
  endtask

  task automatic test_ignore_start();
    check_conv("ignore", 16'h0815, BIN_WIDTH, 815, 1'b0, 5, 16'h9876);
  endtask

  task automatic test_reset_mid_op();
    logic early_done;
    logic late_done;
    early_done = 1'b0;
    late_done  = 1'b0;
    set_bcd(16'h5678);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (done_tick === 1'b1) early_done = 1'b1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || bin_out !== '0 || done_tick !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: ready=%b bin=%0d done=%b, required 1 0 0", ready, bin_out, done_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_bin_out = '0;
    repeat (20) begin
      @(negedge clk);
      if (done_tick === 1'b1) late_done = 1'b1;
    end
    checks++;
    if (early_done || late_done) begin
      failures++;
      $display("FAIL abort_no_done: done_tick seen early=%b late=%b, required none", early_done, late_done);
    end
    checks++;
    if (ready !== 1'b1 || bin_out !== '0) begin
      failures++;
      $display("FAIL abort_idle: ready=%b bin=%0d, required 1 0", ready, bin_out);
    end
  endtask

  task automatic test_err_check();
`ifdef BCD2BIN_ERR_CHECK_EN
    check_conv("invalid", 16'h12A4, 0, 0, 1'b1, 0, 16'h0);
    check_conv("after_invalid", 16'h0042, BIN_WIDTH, 42, 1'b0, 0, 16'h0);
`else
    check_conv("no_err_logic", 16'h0042, BIN_WIDTH, 42, 1'b0, 0, 16'h0);
`endif
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic bad_val;
    logic drained;
    bad_val = 1'b0;
    drained = 1'b0;
    set_bcd(16'h0007);
    start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        done_at.push_back(n);
        if (bin_out !== BIN_WIDTH'(7)) bad_val = 1'b1;
      end
    end
    start = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        drained = 1'b1;
        if (bin_out !== BIN_WIDTH'(7)) bad_val = 1'b1;
      end
    end
    checks++;
    if (done_at.size() !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d done pulses in 40 cycles, required 2", done_at.size());
    end else begin
      checks++;
      if (done_at[0] !== BIN_WIDTH || done_at[1] - done_at[0] !== BIN_WIDTH + 2) begin
        failures++;
        $display("FAIL b2b_spacing: done at %0d and %0d, required %0d and %0d",
                 done_at[0], done_at[1], BIN_WIDTH, 2 * BIN_WIDTH + 2);
      end
    end
    checks++;
    if (bad_val || !drained) begin
      failures++;
      $display("FAIL b2b_value: bad_value=%b drained=%b, required 0 1", bad_val, drained);
    end
    exp_bin_out = BIN_WIDTH'(7);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: ready=%b, required 1", ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] word;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < DIGITS; i++) word[4*i +: 4] = 4'($urandom_range(0, 9));
      check_conv("random", word, BIN_WIDTH, model(word), 1'b0, 0, 16'h0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_bin_out = '0;
    reset = 1'b1;
    start = 1'b0;
    set_bcd(16'h0000);
    test_reset();
    test_zero();
    test_extremes();
    test_ignore_start();
    test_reset_mid_op();
    test_extremes();
    test_err_check();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
